// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  localparam int BOOTH_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  // Step counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
    case ({q0, q_m1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: add/subtract M into A, then
// arithmetic shift right of {A,Q,q_m1} by one bit.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_m1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_m1_o
);

  booth_op_e          op;
  logic      [WIDTH:0] sum;

  // NOTE: combinational blocks use blocking '=' and assign every output
  // before any branch, so no latch can be inferred.
  always_comb begin
    op  = booth_decode(q_i[0], q_m1_i);
    sum = a_i;
    case (op)
      ADD:     sum = a_i + m_i;
      SUB:     sum = a_i - m_i;
      default: sum = a_i;
    endcase
    a_o    = {sum[WIDTH], sum[WIDTH:1]};
    q_o    = {sum[0], q_i[WIDTH-1:1]};
    q_m1_o = q_i[0];
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier: one step per clock, registered
// product with a one-cycle done pulse.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int             CW   = count_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       step_a;
  logic [WIDTH-1:0]     step_q;
  logic                 step_qm1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .q_m1_i (qm1_q),
    .m_i    (m_q),
    .a_o    (step_a),
    .q_o    (step_q),
    .q_m1_o (step_qm1)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = step_a;
        q_d     = step_q;
        qm1_d   = step_qm1;
        count_d = count_q + CW'(1);
        if (count_q == LAST) state_d = DONE;
      end
      DONE: begin
        product_d = {a_q[WIDTH-1:0], q_q};
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy stays high through the done cycle, which follows the DONE state.
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Sequential radix-2 Booth multiplier core for two signed operands. It sits directly below the tt_um_BoothMulti_hhrb98 top-level wrapper, which captures operands from ui_in/uio_in and presents the product bytes on uo_out. The core takes a start pulse and iterates one Booth step per clock. It then pulses done with a registered two's-complement product.

Parameters:
WIDTH, 8, operand width in bits (signed two's complement); product is 2*WIDTH bits

Ports:
clk           input   1          system clock; all state updates on rising edge
rst           input   1          reset; synchronous, active-high
start         input   1          request pulse; sampled only in IDLE
multiplicand  input   WIDTH      signed operand M; captured on accepted start
multiplier    input   WIDTH      signed operand Q; captured on accepted start
busy          output  1          high in RUN and DONE
done          output  1          one-cycle pulse; product valid from this cycle
product       output  2*WIDTH    signed M*Q; held until the next accepted start

Behaviour:
- Reset, sampled at a clk edge while rst=1:
  - state=IDLE; busy=0; done=0; product=0.
  - Internal A, Q, q_m1 and count all cleared.
  - Reset overrides start in the same cycle.
  - Reset mid-RUN aborts the operation; no done pulse follows.
- States:
  - IDLE, start=1: load M (sign-extended to WIDTH+1 bits), A=0 (WIDTH+1 bits), Q=multiplier, q_m1=0, count=0; go to RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, each cycle, one Booth step on bit pair {Q[0],q_m1}:
    - 01: A=A+M.
    - 10: A=A-M.
    - 00 or 11: A unchanged.
    - Then arithmetic shift right of {A,Q,q_m1} by 1; count++.
  - RUN, when count reaches WIDTH-1 (step WIDTH just performed): go to DONE.
  - DONE: product={A[WIDTH-1:0],Q}; done=1 for exactly this cycle; go to IDLE next cycle.
- Widths:
  - A is WIDTH+1 bits so that M=-2^(WIDTH-1) survives subtraction without overflow.
  - A+M and A-M wrap modulo 2^(WIDTH+1); the final result is exact for all operand pairs.
- Latency:
  - Start sampled at edge T gives done=1 and a valid product in the cycle after edge T+WIDTH+1 (9 edges for WIDTH=8).
  - busy rises the cycle after the accepted start and falls the cycle after done.
- Handshake:
  - start while busy=1 is ignored; operands are not recaptured.
  - start held high continuously restarts on the first IDLE cycle after DONE, so back-to-back throughput is one result per WIDTH+2 cycles.
  - Operand inputs may change freely after the start edge.
- product is written only in the DONE transition. It is stable at every other time, including during a following RUN.

Decomposition:
- Package booth_pkg holds:
  - state enum: IDLE, RUN, DONE (2-bit encoding).
  - Booth op encoding: NOP, ADD, SUB.
  - default width constant BOOTH_WIDTH=8.
  - a function computing count width as clog2(WIDTH).
- One combinational sub-module, booth_step, is natural:
  - inputs {A,Q,q_m1} and M; output the next {A,Q,q_m1}.
  - the FSM instantiates it once.

Test Plan:
- Reset then start with M=3, Q=5 -> done pulse exactly 9 edges after the start edge; product=16'h000F; busy=1 throughout the 9 edges of RUN/DONE.
- M=-7 (8'hF9), Q=6 -> product=16'hFFD6 (-42).
- M=-128, Q=-128 -> product=16'h4000; M=-128, Q=127 -> product=16'hC080 (-16256).
- M=2, Q=3 started; start re-pulsed at RUN step 3 with M=9, Q=9 -> single done, product=16'h0006; the next start yields 16'h0051.
- M=10, Q=10 started; rst=1 for one cycle at RUN step 4 -> busy=0, product=0, no done pulse; a new start with M=-1, Q=-1 -> product=16'h0001.
- start held high for 30 cycles with M=1, Q=-1 -> done pulses every 10 cycles, each with product=16'hFFFF.
